blowfish_round_ctrl: RTL and testbench

Sequencing controller for the iterative Blowfish round datapath. It accepts one 64-bit block request at a time (encrypt or decrypt) through a valid/ready handshake and steps the shared round datapath through 16 Feistel rounds plus the output whitening step. It generates the P-array indices in ascending order for encrypt and descending order for decrypt, and presents the result through a valid/ready handshake. The block sits between the requester and the round datapath; it holds only control state, and the L/R registers live in the datapath.

---
 rtl/blowfish_round_ctrl_if.sv | 18 +
 rtl/blowfish_round_ctrl.sv | 107 ++++++++++
 tb/tb_blowfish_round_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blowfish_round_ctrl_if.sv
// Request/result handshake between a block requester and the Blowfish round controller.
interface blowfish_round_ctrl_if;
  logic in_valid;
  logic in_decrypt;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid, in_decrypt, out_ready,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_valid, in_decrypt, out_ready,
    output in_ready, out_valid
  );
endinterface

// File: rtl/blowfish_round_ctrl.sv
// Control sequencer for an iterative Blowfish round datapath: load, ROUNDS Feistel
// steps with P-array indices ascending (encrypt) or descending (decrypt), whitening, deliver.
module blowfish_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int PIDX_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_ready,
  blowfish_round_ctrl_if.slave hs,
  output logic                dp_load,
  output logic                dp_round,
  output logic                dp_final,
  output logic [PIDX_W-1:0]   p_idx_a,
  output logic [PIDX_W-1:0]   p_idx_b,
  output logic                busy,
  output logic                abort
);

  localparam logic [PIDX_W-1:0] LAST_RND = PIDX_W'(ROUNDS - 1);
  localparam logic [PIDX_W-1:0] P_TOP    = PIDX_W'(ROUNDS + 1);
  localparam logic [PIDX_W-1:0] P_FIN    = PIDX_W'(ROUNDS);
  localparam logic [PIDX_W-1:0] P_ONE    = PIDX_W'(1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t            state, state_nx;
  logic [PIDX_W-1:0] rnd, rnd_nx;
  logic              mode, mode_nx;
  logic              abort_nx;
  logic              accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rnd   <= '0;
      mode  <= 1'b0;
      abort <= 1'b0;
    end else begin
      state <= state_nx;
      rnd   <= rnd_nx;
      mode  <= mode_nx;
      abort <= abort_nx;
    end
  end

  // Acceptance is gated by rst as well so nothing is offered while reset is held.
  assign accept = (state == IDLE) & key_ready & ~rst & hs.in_valid;

  always_comb begin
    state_nx     = state;
    rnd_nx       = rnd;
    mode_nx      = mode;
    abort_nx     = 1'b0;
    hs.in_ready  = 1'b0;
    hs.out_valid = 1'b0;
    dp_load      = 1'b0;
    dp_round     = 1'b0;
    dp_final     = 1'b0;
    p_idx_a      = '0;
    p_idx_b      = '0;
    busy         = 1'b0;

    case (state)
      IDLE: begin
        hs.in_ready = key_ready & ~rst;
        dp_load     = accept;
        if (accept) begin
          mode_nx  = hs.in_decrypt;
          rnd_nx   = '0;
          state_nx = ROUND;
        end
      end
      ROUND: begin
        busy     = 1'b1;
        dp_round = 1'b1;
        p_idx_a  = mode ? (P_TOP - rnd) : rnd;
        rnd_nx   = rnd + 1'b1;
        if (rnd == LAST_RND) state_nx = FINAL;
        if (!key_ready) begin
          state_nx = IDLE;
          rnd_nx   = '0;
          abort_nx = 1'b1;
        end
      end
      FINAL: begin
        busy     = 1'b1;
        dp_final = 1'b1;
        p_idx_a  = mode ? P_ONE : P_FIN;
        p_idx_b  = mode ? '0 : P_TOP;
        state_nx = DONE;
        if (!key_ready) begin
          state_nx = IDLE;
          rnd_nx   = '0;
          abort_nx = 1'b1;
        end
      end
      DONE: begin
        busy         = 1'b1;
        hs.out_valid = 1'b1;
        if (hs.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_blowfish_round_ctrl.sv
// Scoreboard bench: a stand-in round datapath driven by the controller, checked against a
// plain Feistel reference with a random P-array and S-boxes, plus index/handshake checks.
module tb_blowfish_round_ctrl;
  localparam int ROUNDS = 16;
  localparam int PIDX_W = 5;

  logic clk = 1'b0;
  logic rst, key_ready;
  logic dp_load, dp_round, dp_final, busy, abort;
  logic [PIDX_W-1:0] p_idx_a, p_idx_b;
  logic [63:0] din;

  blowfish_round_ctrl_if hs();

  blowfish_round_ctrl #(.ROUNDS(ROUNDS), .PIDX_W(PIDX_W)) dut (
    .clk(clk), .rst(rst), .key_ready(key_ready), .hs(hs.slave),
    .dp_load(dp_load), .dp_round(dp_round), .dp_final(dp_final),
    .p_idx_a(p_idx_a), .p_idx_b(p_idx_b), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // Random key material
  logic [31:0] parr [ROUNDS+2];
  logic [31:0] sbox [4][256];

  function automatic logic [31:0] f_fn(input logic [31:0] x);
    return ((sbox[0][x[31:24]] + sbox[1][x[23:16]]) ^ sbox[2][x[15:8]]) + sbox[3][x[7:0]];
  endfunction

  function automatic logic [63:0] ref_crypt(input logic [63:0] blk, input logic dec);
    logic [31:0] xl, xr, t;
    xl = blk[63:32];
    xr = blk[31:0];
    for (int i = 0; i < ROUNDS; i++) begin
      xl = xl ^ parr[dec ? ROUNDS + 1 - i : i];
      xr = xr ^ f_fn(xl);
      t = xl; xl = xr; xr = t;
    end
    t = xl; xl = xr; xr = t;
    xr = xr ^ parr[dec ? 1 : ROUNDS];
    xl = xl ^ parr[dec ? 0 : ROUNDS + 1];
    return {xl, xr};
  endfunction

  // Stand-in datapath following the dp_* command semantics
  logic [31:0] dl, dr;
  always @(posedge clk) begin
    if (dp_load) begin
      dl <= din[63:32];
      dr <= din[31:0];
    end else if (dp_round) begin
      dl <= dr ^ f_fn(dl ^ parr[p_idx_a]);
      dr <= dl ^ parr[p_idx_a];
    end else if (dp_final) begin
      dl <= dr ^ parr[p_idx_b];
      dr <= dl ^ parr[p_idx_a];
    end
  end

  typedef struct {
    logic [63:0] exp;
    logic        aborted;
    int          acc_cyc;
  } sb_t;
  typedef struct {
    logic              fin;
    logic [PIDX_W-1:0] a;
    logic [PIDX_W-1:0] b;
  } ix_t;

  sb_t sbq[$];
  ix_t ixq[$];
  logic prev_ov = 1'b0;
  logic prev_abort = 1'b0;

  // Monitor
  always @(negedge clk) begin
    sb_t s;
    ix_t e;
    if (!rst) begin
      check("dp_exclusive", 64'($countones({dp_load, dp_round, dp_final}) > 1), 64'd0);
      if (!dp_round && !dp_final) check("idx_outside_ops", {p_idx_a, p_idx_b}, '0);
      if (dp_round || dp_final) begin
        if (ixq.size() == 0) fail_now("idx_unexpected_op");
        else begin
          e = ixq.pop_front();
          check("op_kind_final", dp_final, e.fin);
          check("p_idx_a", p_idx_a, e.a);
          if (e.fin) check("p_idx_b", p_idx_b, e.b);
        end
      end
      if (abort) begin
        check("abort_one_cycle", prev_abort, 1'b0);
        ixq.delete();
        if (sbq.size() == 0) fail_now("abort_unexpected");
        else begin
          s = sbq.pop_front();
          check("abort_expected", s.aborted, 1'b1);
        end
      end
      if (hs.out_valid && !prev_ov) begin
        if (sbq.size() == 0) fail_now("out_valid_unexpected");
        else begin
          s = sbq.pop_front();
          check("out_not_aborted", s.aborted, 1'b0);
          check("result", {dl, dr}, s.exp);
          check("latency", 64'(cyc - s.acc_cyc), 64'(ROUNDS + 2));
        end
      end
      if (hs.out_valid) begin
        check("busy_in_done", busy, 1'b1);
        check("in_ready_in_done", hs.in_ready, 1'b0);
      end
      prev_ov    <= hs.out_valid;
      prev_abort <= abort;
    end else begin
      prev_ov    <= 1'b0;
      prev_abort <= 1'b0;
    end
  end

  // Offer a block, wait for acceptance and push the expectations.
  task automatic issue(input logic [63:0] blk, input logic dec, input logic will_abort,
                       output logic ok);
    sb_t s;
    ix_t e;
    int waited;
    @(negedge clk);
    din = blk;
    hs.in_valid = 1'b1;
    hs.in_decrypt = dec;
    waited = 0;
    #1;
    while (!hs.in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    ok = hs.in_ready;
    if (!ok) begin
      fail_now("accept_timeout");
      hs.in_valid = 1'b0;
      return;
    end
    check("dp_load_on_accept", dp_load, 1'b1);
    s.exp = ref_crypt(blk, dec);
    s.aborted = will_abort;
    s.acc_cyc = cyc;
    sbq.push_back(s);
    for (int k = 0; k < ROUNDS; k++) begin
      e.fin = 1'b0;
      e.a = PIDX_W'(dec ? ROUNDS + 1 - k : k);
      e.b = '0;
      ixq.push_back(e);
    end
    e.fin = 1'b1;
    e.a = PIDX_W'(dec ? 1 : ROUNDS);
    e.b = PIDX_W'(dec ? 0 : ROUNDS + 1);
    ixq.push_back(e);
    @(posedge clk);
    #1;
    hs.in_valid = 1'b0;
    hs.in_decrypt = ~dec;
    din = {$urandom, $urandom};
  endtask

  task automatic send(input logic [63:0] blk, input logic dec, input int abort_at,
                      input int bp, input logic drop_in_done);
    logic ok;
    int waited;
    hs.out_ready = (bp == 0);
    issue(blk, dec, abort_at >= 0, ok);
    if (!ok) return;
    if (abort_at >= 0) begin
      repeat (abort_at + 1) @(negedge clk);
      key_ready = 1'b0;
      hs.in_valid = 1'b1;
      repeat (4) begin
        @(negedge clk);
        #1;
        check("no_accept_key_low", hs.in_ready, 1'b0);
        check("no_load_key_low", dp_load, 1'b0);
        check("idle_after_abort", busy, 1'b0);
      end
      hs.in_valid = 1'b0;
      key_ready = 1'b1;
      return;
    end
    waited = 0;
    while (!hs.out_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!hs.out_valid) begin
      fail_now("out_valid_timeout");
      hs.out_ready = 1'b1;
      return;
    end
    if (bp > 0) begin
      if (drop_in_done) key_ready = 1'b0;
      for (int i = 0; i < bp; i++) begin
        check("bp_out_valid", hs.out_valid, 1'b1);
        check("bp_in_ready", hs.in_ready, 1'b0);
        @(negedge clk);
      end
      check("bp_still_valid", hs.out_valid, 1'b1);
      hs.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("idle_after_handshake", busy, 1'b0);
    check("out_valid_dropped", hs.out_valid, 1'b0);
    key_ready = 1'b1;
    #1;
    check("in_ready_after_handshake", hs.in_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ct, blk;
    logic ok;
    int waited;
    rst = 1'b1;
    key_ready = 1'b1;
    hs.in_valid = 1'b1;
    hs.in_decrypt = 1'b0;
    hs.out_ready = 1'b1;
    din = '0;
    for (int i = 0; i < ROUNDS + 2; i++) parr[i] = $urandom;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 256; i++) sbox[b][i] = $urandom;

    repeat (3) @(negedge clk);
    check("rst_in_ready", hs.in_ready, 1'b0);
    check("rst_out_valid", hs.out_valid, 1'b0);
    check("rst_dp", {dp_load, dp_round, dp_final}, 3'b000);
    check("rst_idx", {p_idx_a, p_idx_b}, '0);
    check("rst_busy_abort", {busy, abort}, 2'b00);
    hs.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", hs.in_ready, 1'b1);

    send(64'h0, 1'b0, -1, 0, 1'b0);
    ct = ref_crypt(64'h0, 1'b0);
    send(ct, 1'b1, -1, 0, 1'b0);
    for (int n = 0; n < 8; n++) send({$urandom, $urandom}, 1'($urandom), -1, 0, 1'b0);
    send({$urandom, $urandom}, 1'b0, -1, 5, 1'b0);
    send({$urandom, $urandom}, 1'b1, -1, 3, 1'b1);
    send({$urandom, $urandom}, 1'b0, 7, 0, 1'b0);
    send({$urandom, $urandom}, 1'b1, ROUNDS, 0, 1'b0);
    send({$urandom, $urandom}, 1'b1, 0, 0, 1'b0);
    send({$urandom, $urandom}, 1'b0, -1, 0, 1'b0);

    // Reset in the middle of a block: nothing may come out for it.
    hs.out_ready = 1'b1;
    blk = {$urandom, $urandom};
    issue(blk, 1'b0, 1'b0, ok);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midop_rst_busy", busy, 1'b0);
    check("midop_rst_dp", {dp_load, dp_round, dp_final}, 3'b000);
    check("midop_rst_abort", abort, 1'b0);
    sbq.delete();
    ixq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    send({$urandom, $urandom}, 1'b1, -1, 0, 1'b0);

    waited = 0;
    while (sbq.size() != 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
